// File: rtl/fmul_add_norm.sv
// Final stage of a single-precision multiplier: resolves the carry-save product,
// then normalizes and rounds it to IEEE-754 through a two-entry valid/ready pipeline.
module fmul_add_norm (
  input  logic        clk,
  input  logic        clrn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        sign,
  input  logic [9:0]  exp10,
  input  logic        inf_nan,
  input  logic [22:0] inf_nan_frac,
  input  logic [38:0] z_sum,
  input  logic [39:0] z_carry,
  input  logic [7:0]  z8,
  input  logic [1:0]  rm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] s
);

  typedef enum logic [1:0] {
    RM_RNE = 2'b00,
    RM_RZ  = 2'b01,
    RM_UP  = 2'b10,
    RM_DN  = 2'b11
  } rm_e;

  // stage 1 (add) registers
  logic        s1_valid;
  logic        s1_sign;
  logic [9:0]  s1_exp;
  logic        s1_inf_nan;
  logic [22:0] s1_frac;
  rm_e         s1_rm;
  logic [47:0] s1_z;

  // stage 2 (normalize/round) registers
  logic        s2_valid;

  logic        s2_adv;
  logic        s1_adv;
  logic [39:0] z_hi;

  assign z_hi      = {1'b0, z_sum} + z_carry;
  assign out_valid = s2_valid;
  assign s2_adv    = ~s2_valid | out_ready;
  assign s1_adv    = s2_adv | ~s1_valid;
  assign in_ready  = s1_adv;

  // leading-zero count of s1_z[46:0]; 47 when all clear
  logic [5:0] lz;

  always_comb begin
    lz = 6'd47;
    for (int unsigned i = 0; i < 47; i++) begin
      if (s1_z[i]) lz = 6'(46 - i);
    end
  end

  logic signed [11:0] e_in;
  logic signed [11:0] lz_s;
  logic signed [11:0] cap;
  logic signed [11:0] sh;
  logic signed [11:0] e1;
  logic signed [11:0] rsh;
  logic signed [11:0] e_w;
  logic signed [11:0] exp_f;
  logic [5:0]         rsh_c;
  logic [47:0]        m;
  logic [47:0]        m_n;
  logic               lost;
  logic               guard;
  logic               sticky;
  logic               lsb;
  logic               inc;
  logic [23:0]        mant;
  logic [24:0]        mant25;
  logic [22:0]        frac;
  logic               ovf_inf;
  logic [31:0]        res;

  always_comb begin
    e_in    = {{2{s1_exp[9]}}, s1_exp};
    lz_s    = {6'b0, lz};
    cap     = '0;
    sh      = '0;
    m       = s1_z;
    e1      = e_in;
    rsh     = '0;
    rsh_c   = '0;
    lost    = 1'b0;
    inc     = 1'b0;
    frac    = '0;
    exp_f   = '0;
    ovf_inf = 1'b0;
    res     = '0;

    // Both branches leave the hidden bit at m[47]: a product >= 2.0 is taken as is
    // with exp+1, otherwise shift so the leading one lands on bit 47.
    if (s1_z[47]) begin
      m  = s1_z;
      e1 = e_in + 12'sd1;
    end else begin
      if (e_in > 12'sd1) begin
        cap = e_in - 12'sd1;
        sh  = (lz_s < cap) ? lz_s : cap;
      end
      m  = s1_z << (sh + 12'sd1);
      e1 = e_in - sh;
    end

    // Denormal: slide right until exponent reaches 1; the hidden bit then
    // decides between biased field 1 and 0 further down.
    m_n = m;
    e_w = e1;
    if (e1 < 12'sd1) begin
      rsh   = 12'sd1 - e1;
      rsh_c = (rsh > 12'sd48) ? 6'd48 : rsh[5:0];
      m_n   = m >> rsh_c;
      lost  = |(m & ~({48{1'b1}} << rsh_c));
      e_w   = 12'sd1;
    end

    mant   = m_n[47:24];
    guard  = m_n[23];
    sticky = (|m_n[22:0]) | lost;
    lsb    = mant[0];

    case (s1_rm)
      RM_RNE:  inc = guard & (sticky | lsb);
      RM_RZ:   inc = 1'b0;
      RM_UP:   inc = (guard | sticky) & ~s1_sign;
      RM_DN:   inc = (guard | sticky) & s1_sign;
      default: inc = 1'b0;
    endcase

    mant25 = {1'b0, mant} + {24'b0, inc};

    if (mant25[24]) begin
      exp_f = e_w + 12'sd1;
      frac  = '0;
    end else begin
      exp_f = mant25[23] ? e_w : '0;
      frac  = mant25[22:0];
    end

    ovf_inf = (s1_rm == RM_RNE) | ((s1_rm == RM_UP) & ~s1_sign) |
              ((s1_rm == RM_DN) & s1_sign);

    if (s1_inf_nan)
      res = {s1_sign, 8'hFF, s1_frac};
    else if (s1_z == '0)
      res = {s1_sign, 31'h0};
    else if (mant25 == '0)
      res = {s1_sign, 31'h0};
    else if (exp_f >= 12'sd255)
      res = ovf_inf ? {s1_sign, 8'hFF, 23'h0} : {s1_sign, 31'h7F7FFFFF};
    else
      res = {s1_sign, exp_f[7:0], frac};
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      s1_valid   <= 1'b0;
      s1_sign    <= 1'b0;
      s1_exp     <= '0;
      s1_inf_nan <= 1'b0;
      s1_frac    <= '0;
      s1_rm      <= RM_RNE;
      s1_z       <= '0;
      s2_valid   <= 1'b0;
      s          <= '0;
    end else begin
      if (s1_adv) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_sign    <= sign;
          s1_exp     <= exp10;
          s1_inf_nan <= inf_nan;
          s1_frac    <= inf_nan_frac;
          s1_rm      <= rm_e'(rm);
          s1_z       <= {z_hi, z8};
        end
      end
      if (s2_adv) begin
        s2_valid <= s1_valid;
        if (s1_valid) s <= res;
      end
    end
  end

endmodule

// File: tb/tb_fmul_add_norm.sv
// Self-checking bench for fmul_add_norm: directed corner cases, back-pressure,
// reset flush and a randomized stream against an exact-rounding reference.
module tb_fmul_add_norm;

  logic        clk = 1'b0;
  logic        clrn;
  logic        in_valid;
  logic        in_ready;
  logic        sign;
  logic [9:0]  exp10;
  logic        inf_nan;
  logic [22:0] inf_nan_frac;
  logic [38:0] z_sum;
  logic [39:0] z_carry;
  logic [7:0]  z8;
  logic [1:0]  rm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] s;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fmul_add_norm dut (
    .clk          (clk),
    .clrn         (clrn),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .sign         (sign),
    .exp10        (exp10),
    .inf_nan      (inf_nan),
    .inf_nan_frac (inf_nan_frac),
    .z_sum        (z_sum),
    .z_carry      (z_carry),
    .z8           (z8),
    .rm           (rm),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .s            (s)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Exact value is z * 2^(e-173); quantize at the binary32 ulp for its binade
  // (or the denormal ulp 2^-149), then round by mode.
  function automatic logic [31:0] ref_model(input logic sgn, input logic [9:0] e10,
                                            input logic inan, input logic [22:0] ifrac,
                                            input logic [47:0] z, input logic [1:0] rmode);
    int e, p, be, bef, q, bexp;
    longint unsigned zz, n, one, mask;
    logic g, st, up;
    if (inan) return {sgn, 8'hFF, ifrac};
    if (z == 48'h0) return {sgn, 31'h0};
    e = $signed(e10);
    p = 0;
    for (int i = 0; i < 48; i++) if (z[i]) p = i;
    be  = p - 46 + e;
    bef = (be > 1) ? be : 1;
    q   = bef + 23 - e;
    zz  = z;
    one = 1;
    if (q <= 0) begin
      n = zz << (-q); g = 1'b0; st = 1'b0;
    end else if (q > 48) begin
      n = 0; g = 1'b0; st = 1'b1;
    end else begin
      n    = zz >> q;
      g    = zz[q-1];
      mask = (one << (q - 1)) - 1;
      st   = (zz & mask) != 0;
    end
    case (rmode)
      2'b00:   up = g && (st || n[0]);
      2'b01:   up = 1'b0;
      2'b10:   up = (g || st) && !sgn;
      default: up = (g || st) && sgn;
    endcase
    if (up) n = n + 1;
    if (n == 0) return {sgn, 31'h0};
    if (n >= (one << 24)) begin
      bexp = bef + 1; n = 0;
    end else if (n >= (one << 23)) begin
      bexp = bef; n = n - (one << 23);
    end else begin
      bexp = 0;
    end
    if (bexp >= 255) begin
      if (rmode == 2'b00 || (rmode == 2'b10 && !sgn) || (rmode == 2'b11 && sgn))
        return {sgn, 8'hFF, 23'h0};
      return {sgn, 31'h7F7FFFFF};
    end
    return {sgn, 8'(bexp), n[22:0]};
  endfunction

  task automatic drive(input logic sg, input logic [9:0] e, input logic inan,
                       input logic [22:0] f, input logic [47:0] z, input logic [1:0] r);
    logic [63:0] rnd;
    rnd          = {$urandom, $urandom};
    sign         = sg;
    exp10        = e;
    inf_nan      = inan;
    inf_nan_frac = f;
    z8           = z[7:0];
    z_sum        = rnd[38:0];
    z_carry      = z[47:8] - {1'b0, rnd[38:0]};
    rm           = r;
  endtask

  task automatic gen_item(output logic [31:0] expv);
    logic [63:0] rnd;
    logic [47:0] z;
    logic [9:0]  e;
    logic        sg, inan;
    logic [22:0] f;
    logic [1:0]  r;
    int          kind;
    rnd  = {$urandom, $urandom};
    z    = rnd[47:0] >> $urandom_range(0, 47);
    kind = $urandom_range(0, 15);
    inan = (kind == 0);
    if (kind == 1) z = '0;
    if (kind == 2) z = {24'hFFFFFF, rnd[23:0]};
    case ($urandom_range(0, 3))
      0:       e = 10'($urandom_range(0, 1023));
      1:       e = 10'($urandom_range(0, 40));
      2:       e = 10'(1024 - $urandom_range(1, 30));
      default: e = 10'($urandom_range(230, 260));
    endcase
    sg   = 1'($urandom);
    f    = 23'($urandom);
    r    = 2'($urandom);
    drive(sg, e, inan, f, z, r);
    expv = ref_model(sg, e, inan, f, z, r);
  endtask

  task automatic run_directed(input string tag, input logic sg, input logic [9:0] e,
                              input logic inan, input logic [22:0] f,
                              input logic [47:0] z, input logic [1:0] r,
                              input logic [31:0] expected);
    @(negedge clk);
    drive(sg, e, inan, f, z, r);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    check({tag, "_in_ready"}, {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check({tag, "_lat1_out_valid"}, {31'b0, out_valid}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    #1;
    check({tag, "_lat2_out_valid"}, {31'b0, out_valid}, 32'd1);
    check({tag, "_s"}, s, expected);
  endtask

  // mode 0: always valid, out_ready low for cycles 3..5; mode 1: random valid/ready
  task automatic stream(input string tag, input int n_items, input int max_cyc, input int mode);
    logic [31:0] q[$];
    logic [31:0] nxt_exp;
    logic        have_item;
    int          sent, got, inflight, cyc, low_seen;
    sent = 0; got = 0; inflight = 0; cyc = 0; low_seen = 0; have_item = 1'b0;
    nxt_exp = '0;
    while (got < n_items && cyc < max_cyc) begin
      @(negedge clk);
      if (sent < n_items) begin
        if (!have_item) begin
          gen_item(nxt_exp);
          have_item = 1'b1;
        end
        in_valid = (mode == 0) ? 1'b1 : ($urandom_range(0, 9) < 7);
      end else begin
        in_valid = 1'b0;
      end
      out_ready = (mode == 0) ? !(cyc >= 3 && cyc <= 5) : ($urandom_range(0, 9) < 7);
      #1;
      check({tag, "_in_ready"}, {31'b0, in_ready}, {31'b0, (inflight < 2) || out_ready});
      if (!in_ready) low_seen++;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check({tag, "_spurious_out"}, {31'b0, out_valid}, 32'd0);
        end else begin
          check({tag, "_s"}, s, q.pop_front());
          got++;
          inflight--;
        end
      end
      if (in_valid && in_ready) begin
        q.push_back(nxt_exp);
        have_item = 1'b0;
        sent++;
        inflight++;
      end
      cyc++;
    end
    check({tag, "_count"}, got, n_items);
    if (mode == 0) check({tag, "_in_ready_low_seen"}, {31'b0, low_seen > 0}, 32'd1);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    check({tag, "_drained"}, {31'b0, out_valid}, 32'd0);
  endtask

  logic [31:0] dummy;

  initial begin
    clrn = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    drive(1'b0, '0, 1'b0, '0, '0, 2'b00);
    #1;
    check("reset_out_valid", {31'b0, out_valid}, 32'd0);
    check("reset_s", s, 32'h0);
    check("reset_in_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    clrn = 1'b1;

    run_directed("mul_1p5x1p5", 1'b0, 10'd127, 1'b0, '0, 48'h900000000000, 2'b00, 32'h40100000);
    run_directed("rne_tie_even", 1'b0, 10'd127, 1'b0, '0, 48'h800000800000, 2'b00, 32'h40000000);
    run_directed("rne_tie_odd", 1'b0, 10'd127, 1'b0, '0, 48'h800001800000, 2'b00, 32'h40000002);
    run_directed("rup_neg", 1'b1, 10'd127, 1'b0, '0, 48'h800001800000, 2'b10, 32'hC0000001);
    run_directed("ovf_rne", 1'b0, 10'd300, 1'b0, '0, 48'h800000000000, 2'b00, 32'h7F800000);
    run_directed("ovf_rz", 1'b0, 10'd300, 1'b0, '0, 48'h800000000000, 2'b01, 32'h7F7FFFFF);
    run_directed("ovf_rup_neg", 1'b1, 10'd300, 1'b0, '0, 48'h800000000000, 2'b10, 32'hFF7FFFFF);
    run_directed("nan", 1'b0, 10'd0, 1'b1, 23'h400000, 48'h123456789ABC, 2'b00, 32'h7FC00000);
    run_directed("zero_neg", 1'b1, 10'd200, 1'b0, '0, 48'h0, 2'b00, 32'h80000000);
    run_directed("denormal", 1'b0, 10'h3FB, 1'b0, '0, 48'h400000000000, 2'b00, 32'h00020000);
    run_directed("carry_renorm", 1'b0, 10'd127, 1'b0, '0, 48'hFFFFFF800000, 2'b00, 32'h40800000);

    // fill both stages, then reset mid-cycle
    @(negedge clk);
    gen_item(dummy);
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    #1;
    check("full_out_valid", {31'b0, out_valid}, 32'd1);
    check("full_in_ready", {31'b0, in_ready}, 32'd0);
    #2;
    clrn = 1'b0;
    #1;
    check("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    check("midrst_s", s, 32'h0);
    check("midrst_in_ready", {31'b0, in_ready}, 32'd1);
    in_valid = 1'b0;
    @(negedge clk);
    clrn      = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      check("post_rst_no_stale", {31'b0, out_valid}, 32'd0);
    end
    run_directed("post_rst_fresh", 1'b0, 10'd127, 1'b0, '0, 48'h900000000000, 2'b00, 32'h40100000);

    stream("bp8", 8, 60, 0);
    stream("rand", 300, 3000, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fmul_add_norm.md
FMUL_ADD_NORM -- requirements
Module: fmul_add_norm

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 clrn  input  1  asynchronous active-low reset; clears all state immediately, independent of clk.
REQ-003 in_valid  input  1  upstream multiplier-stage outputs valid this cycle.
REQ-004 in_ready  output  1  block accepts the input when in_valid & in_ready.
REQ-005 sign  input  1  product sign.
REQ-006 exp10  input  10  biased product exponent, two's complement, already corrected for denormal operands.
REQ-007 inf_nan  input  1  product is inf or NaN.
REQ-008 inf_nan_frac  input  23  fraction to emit when inf_nan; nonzero marks NaN.
REQ-009 z_sum  input  39  partial-sum bits of product[47:8].
REQ-010 z_carry  input  40  partial-carry bits of product[47:8].
REQ-011 z8  input  8  product[7:0].
REQ-012 rm  input  2  rounding mode, sampled with the data: 00 nearest-even, 01 toward zero, 10 toward +inf, 11 toward -inf.
REQ-013 out_valid  output  1  result valid.
REQ-014 out_ready  input  1  downstream accepts when out_valid & out_ready.
REQ-015 s  output  32  IEEE-754 single result.

Function
REQ-016 Two register stages S1 (add) and S2 (normalize/round); each holds a valid bit and its payload.
REQ-017 S1 SHALL capture sign, exp10, inf_nan, inf_nan_frac, rm and product z[47:0] = {({1'b0,z_sum} + z_carry)[39:0], z8} on acceptance.
REQ-018 S2 SHALL capture the normalized, rounded 32-bit result computed from S1 contents when S1 advances.
REQ-019 Latency: exactly 2 cycles from input acceptance to out_valid with no back-pressure; throughput one result per cycle.
REQ-020 S2 advances when ~out_valid | out_ready; S1 advances when S2 advances or S1 empty; in_ready = ~s1_valid | s2_advance (combinational, no bubble on full-rate flow).
REQ-021 When out_valid & ~out_ready, s and out_valid SHALL hold unchanged; S1 holds if also full; no data loss or duplication.
REQ-022 Normalize: if z[47]=1, mantissa = z[47:24], exp+1; else leading-zero count of z[46:0] shifts left, exp decremented, shift capped so exp stays >= 1.
REQ-023 If working exp <= 0: shift right by (1 - exp), OR-ing shifted-out bits into sticky, biased exp field 0 (denormal result).
REQ-024 Guard = first bit below mantissa LSB, sticky = OR of all lower bits; increment per rm: RNE guard&(sticky|lsb); RZ never; +inf (guard|sticky)&~sign; -inf (guard|sticky)&sign.
REQ-025 Round carry-out SHALL renormalize (exp+1, mantissa 1.0); denormal rounding into hidden bit yields exp field 1.
REQ-026 Overflow (final biased exp >= 255): RNE -> inf; RZ -> max finite 0x7F7FFFFF with sign; +inf mode -> inf if positive else max finite; -inf mode -> inf if negative else max finite.
REQ-027 Zero product (z = 0) SHALL yield signed zero {sign, 31'h0} regardless of exp10.
REQ-028 inf_nan=1 SHALL bypass arithmetic: s = {sign, 8'hFF, inf_nan_frac}.
REQ-029 Underflow to zero after rounding SHALL yield {sign, 31'h0}.

Reset
REQ-030 clrn low SHALL force s1_valid=0, s2_valid=0, out_valid=0, s=32'h0 asynchronously; in_ready=1 while in reset.
REQ-031 Reset mid-operation SHALL discard all in-flight results; first result after release comes only from inputs accepted after release.

Verification
REQ-032 1.5 x 1.5: sign=0, exp10=127, z_sum/z_carry/z8 encoding product 0x900000<<24 ... i.e. z=48'h900000000000, rm=00 -> s=0x40100000 two cycles after accept.
REQ-033 Rounding: z with guard=1, sticky=0, lsb=0 under rm=00 -> no increment; same with lsb=1 -> increment; rm=10, sign=1 -> no increment.
REQ-034 Overflow: exp10=300, z[47]=1 -> rm=00 s=0x7F800000; rm=01 s=0x7F7FFFFF; sign=1, rm=10 -> 0xFF7FFFFF.
REQ-035 Special: inf_nan=1, inf_nan_frac=0x400000, sign=0 -> s=0x7FC00000; z=0, sign=1 -> 0x80000000; exp10=-5 with z[46]=1 -> denormal per REQ-023.
REQ-036 Back-pressure: stream 8 back-to-back inputs, hold out_ready=0 for 3 cycles mid-stream -> all 8 results emerge in order, none dropped or repeated, in_ready low while both stages full.
REQ-037 Reset: assert clrn low with both stages full -> out_valid=0, s=0 immediately; after release, no stale result appears.
